// File: rtl/sub_pipe_pkg.sv
// rtl/sub_pipe_pkg.sv - shared constants, stage sizing and stage register type
// for the pipelined lookahead subtractor.
package sub_pipe_pkg;

  localparam int SUB_WIDTH = 53;
  localparam int SUB_CHUNK = 14;

  function automatic int f_nstage(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // bout is the stage's carry-out held inverted, so a cleared register reads as no borrow
  typedef struct packed {
    logic                 valid;
    logic [SUB_WIDTH-1:0] diff;
    logic                 bout;
    logic [SUB_WIDTH-1:0] a;
    logic [SUB_WIDTH-1:0] b;
  } sub_stage_t;

endpackage

// File: rtl/sub_chunk_cla.sv
// rtl/sub_chunk_cla.sv - combinational W-bit slice computing a + ~b + cin
// with generate/propagate carry lookahead.
module sub_chunk_cla #(
  parameter int W = 14
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] d,
  output logic         cout
);

  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W:0]   w_c;

  assign w_g = a & ~b;
  assign w_p = a | ~b;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < W; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign d    = a ^ ~b ^ w_c[W-1:0];
  assign cout = w_c[W];

endmodule

// File: rtl/sub_pipe_53bit.sv
// rtl/sub_pipe_53bit.sv - pipelined i_min - i_sub - i_bin, one slice per stage,
// global-stall valid/ready flow control.
module sub_pipe_53bit
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int CHUNK = SUB_CHUNK
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  input  logic             i_bin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
);

  localparam int NSTAGE = f_nstage(WIDTH, CHUNK);

  sub_stage_t r_stage [NSTAGE];
  sub_stage_t w_next  [NSTAGE];
  logic       w_adv;
  logic       w_unused;

  assign w_adv = ~r_stage[NSTAGE-1].valid | i_ready;

  genvar s;
  generate
    for (s = 0; s < NSTAGE; s++) begin : g_stage
      localparam int LO = s * CHUNK;
      localparam int SW = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;

      sub_stage_t    w_src;
      sub_stage_t    w_nxt;
      logic          w_cin;
      logic [SW-1:0] w_d;
      logic          w_cout;

      if (s == 0) begin : g_head
        assign w_src = '{valid: i_valid, diff: '0, bout: 1'b0, a: i_min, b: i_sub};
        assign w_cin = ~i_bin;
      end else begin : g_body
        assign w_src = r_stage[s-1];
        assign w_cin = ~r_stage[s-1].bout;
      end

      sub_chunk_cla #(.W(SW)) u_cla (
        .a    (w_src.a[LO +: SW]),
        .b    (w_src.b[LO +: SW]),
        .cin  (w_cin),
        .d    (w_d),
        .cout (w_cout)
      );

      always_comb begin
        w_nxt                 = w_src;
        w_nxt.diff[LO +: SW]  = w_d;
        w_nxt.bout            = ~w_cout;
      end

      assign w_next[s] = w_nxt;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NSTAGE; i++) r_stage[i] <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < NSTAGE; i++) r_stage[i] <= w_next[i];
    end
  end

  // operands are fully consumed by the last stage
  assign w_unused = ^{r_stage[NSTAGE-1].a, r_stage[NSTAGE-1].b};

  assign o_ready  = w_adv;
  assign o_valid  = r_stage[NSTAGE-1].valid;
  assign o_result = {r_stage[NSTAGE-1].bout, r_stage[NSTAGE-1].diff};

endmodule

// File: tb/tb_sub_pipe_53bit.sv
// tb/tb_sub_pipe_53bit.sv - directed table-driven bench for sub_pipe_53bit.
module tb_sub_pipe_53bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [52:0] min_v = '0;
  logic [52:0] sub_v = '0;
  logic        bin_v = 1'b0;
  logic        out_valid;
  logic        in_ready = 1'b1;
  logic [53:0] result;

  int n_pass  = 0;
  int n_total = 0;

  sub_pipe_53bit dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (in_valid),
    .o_ready  (out_ready),
    .i_min    (min_v),
    .i_sub    (sub_v),
    .i_bin    (bin_v),
    .o_valid  (out_valid),
    .i_ready  (in_ready),
    .o_result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [52:0] min;
    logic [52:0] sub;
    logic        bin;
    logic [53:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_one(input vec_t v);
    int lat;
    @(negedge clk);
    min_v = v.min; sub_v = v.sub; bin_v = v.bin; in_valid = 1'b1; in_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 64'(lat), 64'd4);
    check({v.name, " result"}, 64'(result), 64'(v.exp));
    @(negedge clk);
    check({v.name, " single pulse"}, 64'(out_valid), 64'd0);
  endtask

  logic [53:0] bp_exp [8];
  logic [52:0] bp_min [8];
  logic [52:0] bp_sub [8];

  initial begin
    vecs[0] = '{"basic",      53'd5,                  53'd3,                  1'b0, 54'h2};
    vecs[1] = '{"underflow",  53'd0,                  53'd1,                  1'b0, {1'b1, 53'h1F_FFFF_FFFF_FFFF}};
    vecs[2] = '{"s0 border",  53'h4000,               53'd1,                  1'b0, 54'h3FFF};
    vecs[3] = '{"top border", 53'h10_0000_0000_0000,  53'd1,                  1'b0, {1'b0, 53'h0F_FFFF_FFFF_FFFF}};
    vecs[4] = '{"borrow-in",  53'h1234,               53'h1234,               1'b1, {1'b1, 53'h1F_FFFF_FFFF_FFFF}};
    vecs[5] = '{"s2 border",  53'h400_0000_0000,      53'd1,                  1'b0, 54'h3FF_FFFF_FFFF};
    vecs[6] = '{"max-max",    53'h1F_FFFF_FFFF_FFFF,  53'h1F_FFFF_FFFF_FFFF,  1'b0, 54'h0};
    vecs[7] = '{"max-0-bin",  53'h1F_FFFF_FFFF_FFFF,  53'd0,                  1'b1, 54'h1F_FFFF_FFFF_FFFE};
    vecs[8] = '{"small",      53'h100,                53'h37,                 1'b0, 54'hC9};
    vecs[9] = '{"zero-bin",   53'd0,                  53'd0,                  1'b1, {1'b1, 53'h1F_FFFF_FFFF_FFFF}};

    for (int k = 0; k < 8; k++) begin
      bp_min[k] = 53'h4000 * 53'(k) + 53'(k);
      bp_sub[k] = 53'(k + 1);
      bp_exp[k] = {1'b0, bp_min[k]} - {1'b0, bp_sub[k]} - 54'(k % 2);
    end

    #2 rst = 1'b1;
    #1;
    check("reset o_valid", 64'(out_valid), 64'd0);
    check("reset o_result", 64'(result), 64'd0);
    check("reset o_ready", 64'(out_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_one(vecs[i]);

    begin : backpressure
      int sent, got, cyc;
      logic acc, drain, held_v;
      logic [53:0] held_r;
      sent = 0; got = 0; cyc = 0; held_r = '0; held_v = 1'b0;
      while (got < 8 && cyc < 60) begin
        @(negedge clk);
        in_ready = !(cyc >= 6 && cyc <= 8);
        if (sent < 8) begin
          min_v = bp_min[sent]; sub_v = bp_sub[sent]; bin_v = sent[0]; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        acc   = in_valid && out_ready;
        drain = out_valid && in_ready;
        if (!in_ready) begin
          check("stall o_ready", 64'(out_ready), 64'd0);
          if (cyc == 6) begin
            held_r = result; held_v = out_valid;
            check("stall o_valid", 64'(out_valid), 64'd1);
          end else begin
            check("stall o_result stable", 64'(result), 64'(held_r));
            check("stall o_valid stable", 64'(out_valid), 64'(held_v));
          end
        end
        if (drain) begin
          check($sformatf("bp item %0d", got), 64'(result), 64'(bp_exp[got]));
          got++;
        end
        @(posedge clk);
        if (acc) sent++;
        cyc++;
      end
      check("bp items drained", 64'(got), 64'd8);
      @(negedge clk); in_valid = 1'b0; in_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (out_valid) got++;
      end
      check("bp no duplicates", 64'(got), 64'd0);
    end

    begin : reset_mid
      int seen;
      vec_t v;
      @(negedge clk);
      min_v = 53'd100; sub_v = 53'd1; bin_v = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      min_v = 53'd200;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("pre-reset o_valid", 64'(out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async reset o_valid", 64'(out_valid), 64'd0);
      check("async reset o_result", 64'(result), 64'd0);
      check("async reset o_ready", 64'(out_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("post-reset idle", 64'(seen), 64'd0);
      v = '{"post-reset", 53'd9, 53'd4, 1'b0, 54'h5};
      run_one(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sub_pipe_53bit.md
# sub_pipe_53bit

Pipelined 53-bit lookahead subtractor, the inverse arithmetic path to the 53-bit carry-lookahead adder. It computes `i_min − i_sub − i_bin` over `NSTAGE` register stages, processing one `CHUNK`-bit slice per stage with in-slice lookahead and a registered borrow between slices. A valid/ready handshake on both sides gives one result per cycle sustained, with full backpressure. It sits beside the adder in the datapath wherever 53-bit significands are differenced.

## Interface
- `WIDTH`, default 53: operand width.
- `CHUNK`, default 14: bits resolved per stage.
- `NSTAGE`, derived as ceil(WIDTH/CHUNK) = 4 at the defaults; not overridable.

- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_valid`  in  1: input operands valid.
- `o_ready`  out  1: block can accept an input this cycle.
- `i_min`  in  WIDTH: minuend.
- `i_sub`  in  WIDTH: subtrahend.
- `i_bin`  in  1: borrow-in, used for multiword chaining.
- `o_valid`  out  1: result valid.
- `i_ready`  in  1: downstream accepts the result.
- `o_result`  out  WIDTH+1: bit WIDTH is borrow-out; bits WIDTH-1:0 are the difference mod 2^WIDTH.

## Operation
- **Arithmetic.** Computed as `i_min + ~i_sub + ~i_bin`.
  - Per-bit terms: generate = `a & ~b`, propagate = `a | ~b`.
  - Carry into slice 0 = `~i_bin`.
  - Borrow-out = the inverted carry out of the top slice.
  - The result is exact for all inputs; there are no saturation or overflow flags.
- **Slicing.** Slice k covers bits [k·CHUNK, min((k+1)·CHUNK, WIDTH)−1]. At the defaults the slices are 14/14/14/11 bits.
- **Stage s register holds:**
  - the valid bit `v[s]`;
  - the difference bits for slices 0..s;
  - the carry out of slice s;
  - the not-yet-processed operand bits for slices s+1..NSTAGE−1.
- **Stage behaviour.**
  - Stage 0 loads from the ports.
  - Stage s>0 loads from stage s−1, resolving slice s using the carry registered by stage s−1.
- **Flow control (global stall).**
  - `adv = ~v[NSTAGE−1] | i_ready`.
  - `o_ready = adv`.
  - When `adv` is 1, every stage loads from its predecessor, and `v[0] ← i_valid`.
  - When `adv` is 0, no register changes.
  - Bubbles are not collapsed. Ordering is strictly FIFO.
- **Outputs.**
  - `o_valid = v[NSTAGE−1]`.
  - `o_result` is driven from the last stage register.
  - While `o_valid & ~i_ready`, `o_result` is held stable.
- **Simultaneous input and output.** An accept on the input and a drain on the output in the same cycle is allowed; throughput is 1 per cycle.
- **Reset.**
  - Asynchronous: all `v[]` clear to 0 and all data registers clear to 0 immediately.
  - `o_valid` = 0, `o_result` = 0.
  - `o_ready` = 1 while reset is asserted (pipeline empty), but nothing is captured until the first edge after deassertion.
  - Any transactions in flight are discarded.
- Inputs presented while `o_ready` is 0 are ignored. Upstream must hold them until accepted.

## Timing
- **Latency:** an input accepted at the edge ending cycle t produces `o_valid` = 1 in cycle t+NSTAGE (t+4 at the defaults), given `i_ready` was 1 throughout.
- **Stalls:** each stalled cycle adds exactly one cycle of latency to every in-flight item.
- **Critical path:** one CHUNK-bit lookahead plus one register. No path depends combinationally on WIDTH.
- **Combinational paths:**
  - `o_ready` depends combinationally on `i_ready`; this is accepted.
  - `o_valid` and `o_result` are registered only.

## Structure
- **Shared package `sub_pipe_pkg`:**
  - constants `SUB_WIDTH` (53) and `SUB_CHUNK` (14);
  - function `f_nstage(width, chunk)` returning the ceiling division;
  - a packed struct type for the stage register: valid, difference, carry, remaining operands.
- **Sub-module `sub_chunk_cla`:**
  - purely combinational;
  - parameter `W`;
  - inputs `a[W]`, `b[W]`, `cin`;
  - outputs `d[W]`, `cout`;
  - internal generate/propagate lookahead.
  - Instantiated once per stage through a generate loop. The last instance is narrowed to the remainder width.

## Test plan
- **Basic difference:** `i_min`=5, `i_sub`=3, `i_bin`=0, `i_ready`=1 → `o_result`=54'h2 exactly 4 cycles after accept; `o_valid` is high for exactly one cycle.
- **Underflow:** `i_min`=0, `i_sub`=1 → `o_result`={1'b1, 53'h1F_FFFF_FFFF_FFFF}.
- **Slice-boundary borrow:** `i_min`=53'h4000, `i_sub`=1 → `o_result`=54'h3FFF, borrow 0. Then `i_min`=53'h10_0000_0000_0000, `i_sub`=1 → 53'h0F_FFFF_FFFF_FFFF, borrow 0.
- **Borrow-in:** `i_min`=`i_sub`=53'h1234, `i_bin`=1 → `o_result`={1'b1, all ones}.
- **Backpressure:** 8 back-to-back transactions with `i_ready` pulled low for 3 cycles mid-stream. Required:
  - `o_ready` is low during the stall;
  - `o_result` and `o_valid` are stable during the stall;
  - all 8 results appear in order, none lost or duplicated.
- **Reset mid-stream:** assert `i_rst` with 2 items in flight. Required:
  - `o_valid` goes to 0 immediately (asynchronously);
  - `o_result` = 0;
  - after release, no output appears until a new accept, and that result arrives 4 cycles later.
